unary_multiply_const: RTL

UNARY_MULTIPLY_CONST -- requirements
Module: unary_multiply_const

---
 rtl/unary_pkg.sv | 19 +
 rtl/unary_bound_calc.sv | 57 +++++
 rtl/unary_multiply_const.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/unary_pkg.sv
// Shared types and width helpers for the unary bitstream scalers.
package unary_pkg;

   typedef enum logic [1:0] {
      S_RUN   = 2'd0,
      S_FLUSH = 2'd1,
      S_DONE  = 2'd2
   } state_e;

   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

   // Bounds hold up to K*N, so they need log2(K+1) bits beyond the counters.
   function automatic int bound_width(input int cw, input int k);
      return cw + $clog2(k + 1);
   endfunction

endpackage

// File: rtl/unary_bound_calc.sv
// Combinational bound and commit decision for a constant-K unary scaler.
module unary_bound_calc
   import unary_pkg::*;
#(
   parameter int N       = 32,
   parameter int K       = 2,
   parameter int EPSILON = 0,
   parameter int CW      = cnt_width(N),
   parameter int BW      = bound_width(CW, K)
) (
   input  logic [CW-1:0] k_i,
   input  logic [CW-1:0] p_i,
   input  logic [CW-1:0] m_i,
   input  logic [CW-1:0] q_i,
   output logic          commit_o,
   output logic          bit_o
);

   localparam int            EPS_C = (EPSILON > N) ? N : EPSILON;
   localparam logic [BW-1:0] N_B   = BW'(N);
   localparam logic [BW-1:0] K_B   = BW'(K);
   localparam logic [BW-1:0] EPS_B = BW'(EPS_C);
   localparam logic [CW-1:0] N_C   = CW'(N);

   logic [BW-1:0] prod_lo, prod_hi, lo, hi, q_b, r_b;
   logic          active, need_one, can_zero;

   // Products are clamped to N before any compare.
   assign prod_lo = K_B * BW'(p_i);
   assign prod_hi = K_B * (BW'(p_i) + N_B - BW'(k_i));
   assign lo      = (prod_lo > N_B) ? N_B : prod_lo;
   assign hi      = (prod_hi > N_B) ? N_B : prod_hi;
   assign q_b     = BW'(q_i);
   assign r_b     = N_B - BW'(m_i);

   // No output before the first accepted input, none past the frame end.
   assign active   = (m_i < N_C) && (k_i != '0);
   assign need_one = (q_b < lo) || ((q_b + r_b) <= lo);
   assign can_zero = (q_b + r_b - BW'(1)) >= hi;

   always_comb begin
      commit_o = 1'b0;
      bit_o    = 1'b0;
      if (active) begin
         if (need_one) begin
            commit_o = 1'b1;
            bit_o    = 1'b1;
         end else if (can_zero) begin
            commit_o = 1'b1;
         end else if ((hi - lo) <= EPS_B) begin
            commit_o = 1'b1;
            bit_o    = ((q_b + q_b) < (lo + hi));
         end
      end
   end

endmodule

// File: rtl/unary_multiply_const.sv
// Unary bitstream multiply by constant K with min(N, K*P) saturation.
// Optional sat flag port enabled by defining UNARY_MUL_SAT_FLAG_EN.
module unary_multiply_const
   import unary_pkg::*;
#(
   parameter int INPUT_WIDTH = 32,
   parameter int SCALE       = 2,
   parameter int EPSILON     = 0,
   parameter int COUNT_WIDTH = $clog2(INPUT_WIDTH + 1)
) (
   input  logic clk,
   input  logic reset,
   input  logic a,
   input  logic a_valid,
   output logic a_ready,
   output logic y,
   output logic y_valid,
   input  logic y_ready,
   output logic done
`ifdef UNARY_MUL_SAT_FLAG_EN
   ,
   output logic sat
`endif
);

   // state   | meaning
   // S_RUN   | accepting input bits and committing output bits
   // S_FLUSH | all N inputs taken, committing remaining outputs
   // S_DONE  | one-cycle frame end, counters cleared

   localparam int                     BW  = bound_width(COUNT_WIDTH, SCALE);
   localparam logic [COUNT_WIDTH-1:0] N_C = COUNT_WIDTH'(INPUT_WIDTH);
   localparam logic [COUNT_WIDTH-1:0] ONE = COUNT_WIDTH'(1);

   state_e                 state_q, state_d;
   logic [COUNT_WIDTH-1:0] k_q, k_d, p_q, p_d, m_q, m_d, q_q, q_d;
   logic                   y_q, y_d, y_valid_q, y_valid_d;
   logic                   calc_commit, calc_bit, commit_now, accept, out_free;

   unary_bound_calc #(
      .N       (INPUT_WIDTH),
      .K       (SCALE),
      .EPSILON (EPSILON),
      .CW      (COUNT_WIDTH),
      .BW      (BW)
   ) u_bound (
      .k_i      (k_q),
      .p_i      (p_q),
      .m_i      (m_q),
      .q_i      (q_q),
      .commit_o (calc_commit),
      .bit_o    (calc_bit)
   );

   assign a_ready    = (state_q == S_RUN) && (k_q < N_C);
   assign accept     = a_valid && a_ready;
   assign out_free   = !y_valid_q || y_ready;
   assign commit_now = calc_commit && out_free && (state_q != S_DONE);

   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      p_d       = p_q;
      m_d       = m_q;
      q_d       = q_q;
      y_d       = y_q;
      y_valid_d = y_valid_q;

      if (accept) begin
         k_d = k_q + ONE;
         p_d = p_q + COUNT_WIDTH'(a);
      end
      if (y_valid_q && y_ready) y_valid_d = 1'b0;
      // Decision comes from the registered counters, before this cycle's accept.
      if (commit_now) begin
         y_d       = calc_bit;
         y_valid_d = 1'b1;
         m_d       = m_q + ONE;
         if (calc_bit) q_d = q_q + ONE;
      end

      case (state_q)
         S_RUN: begin
            if (k_d == N_C) state_d = S_FLUSH;
         end
         S_FLUSH: begin
            if ((m_q == N_C) && out_free) state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_RUN;
            k_d     = '0;
            p_d     = '0;
            m_d     = '0;
            q_d     = '0;
         end
         default: state_d = S_RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_RUN;
         k_q       <= '0;
         p_q       <= '0;
         m_q       <= '0;
         q_q       <= '0;
         y_q       <= 1'b0;
         y_valid_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         k_q       <= k_d;
         p_q       <= p_d;
         m_q       <= m_d;
         q_q       <= q_d;
         y_q       <= y_d;
         y_valid_q <= y_valid_d;
      end
   end

   assign y       = y_q;
   assign y_valid = y_valid_q;
   assign done    = (state_q == S_DONE);

`ifdef UNARY_MUL_SAT_FLAG_EN
   logic          sat_q, sat_d;
   logic [BW-1:0] kp_next;

   assign kp_next = BW'(SCALE) * BW'(p_d);

   // Sticky for the frame; already low while the frame-end cycle is shown.
   always_comb begin
      sat_d = sat_q || (kp_next > BW'(INPUT_WIDTH));
      if (state_d == S_DONE) sat_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) sat_q <= 1'b0;
      else       sat_q <= sat_d;
   end

   assign sat = sat_q;
`endif

endmodule
